seg7_capture: RTL and testbench

- Inverse of the BCD-to-seven-segment path. Watches a multiplexed, active-low seven-segment display bus (digit selects plus segment pattern) and decodes each pattern back to BCD.
- Assembles a full NUM_DIGITS frame and hands it out over a valid/ready handshake.
- Used as a loopback checker on display outputs and to read external segment displays.

---
 rtl/seg7_capture_pkg.sv | 32 +++
 rtl/seg7_capture_pattern_decode.sv | 44 ++++
 rtl/seg7_capture.sv | 189 ++++++++++++++++++
 tb/tb_seg7_capture.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_capture_pkg.sv
// Shared constants for seg7_capture: active-low segment patterns (bit6=g .. bit0=a),
// the error nibble and the digit tracker state encoding.
package seg7_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  localparam logic [3:0] ERR_CODE = 4'hE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_capture_pattern_decode.sv
// Combinational active-low seven-segment pattern to BCD decoder.
// Hex letters A-F are recognised only when SEG7_CAPTURE_HEX_EN is defined.
module seg7_pattern_decode
  import seg7_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o,
  output logic       blank_o
);

  // pattern lookup; anything unlisted is flagged as an error
  always_comb begin
    bcd_o   = 4'h0;
    err_o   = 1'b0;
    blank_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'h0;
      SEG_1:     bcd_o = 4'h1;
      SEG_2:     bcd_o = 4'h2;
      SEG_3:     bcd_o = 4'h3;
      SEG_4:     bcd_o = 4'h4;
      SEG_5:     bcd_o = 4'h5;
      SEG_6:     bcd_o = 4'h6;
      SEG_7:     bcd_o = 4'h7;
      SEG_8:     bcd_o = 4'h8;
      SEG_9:     bcd_o = 4'h9;
      SEG_BLANK: blank_o = 1'b1;
`ifdef SEG7_CAPTURE_HEX_EN
      SEG_HEX_A: bcd_o = 4'hA;
      SEG_HEX_B: bcd_o = 4'hB;
      SEG_HEX_C: bcd_o = 4'hC;
      SEG_HEX_D: bcd_o = 4'hD;
      SEG_HEX_E: bcd_o = 4'hE;
      SEG_HEX_F: bcd_o = 4'hF;
`endif
      default: begin
        bcd_o = ERR_CODE;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Multiplexed seven-segment bus capture: debounces each digit, assembles a frame and
// offers it over valid/ready. Hex decoding is enabled by SEG7_CAPTURE_HEX_EN.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0]      STABLE_C = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_DIGITS-1:0] DIG_ZERO = {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  state_e                  state_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [NUM_DIGITS-1:0]   an_low_s;
  logic                    an_ok_s;
  logic                    changed_s;
  logic [CNT_W-1:0]        cnt_inc_s;
  logic                    start_s;
  logic                    settle_done_s;
  logic                    accept_s;

  logic [3:0]              dec_bcd_s;
  logic                    dec_err_s;
  logic                    dec_blank_s;

  logic                    frame_full_s;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d;
  logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
  logic [NUM_DIGITS-1:0]   work_blank_q, work_blank_d;
  logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
  logic [NUM_DIGITS-1:0]   digit_blank_q, digit_blank_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    overrun_q, overrun_d;

  seg7_pattern_decode u_decode (
    .seg_i   (seg),
    .bcd_o   (dec_bcd_s),
    .err_o   (dec_err_s),
    .blank_o (dec_blank_s)
  );

  // tracker decisions: start a new settle window, or finish the current one
  always_comb begin
    an_low_s      = ~an;
    an_ok_s       = (an_low_s != DIG_ZERO) && ((an_low_s & (an_low_s - DIG_ONE)) == DIG_ZERO);
    changed_s     = (an != an_q) || (seg != seg_q);
    cnt_inc_s     = cnt_q + CNT_ONE;
    start_s       = 1'b0;
    settle_done_s = 1'b0;
    case (state_q)
      IDLE:   start_s = an_ok_s;
      SETTLE: begin
        if (changed_s) begin
          start_s = an_ok_s;
        end else begin
          settle_done_s = (cnt_inc_s == STABLE_C);
        end
      end
      LOCKED: start_s = changed_s && an_ok_s;
      default: start_s = 1'b0;
    endcase
    // a one-cycle window accepts on the very cycle the digit first appears
    accept_s = settle_done_s || (start_s && (STABLE_C == CNT_ONE));
  end

  // digit tracker FSM shared by all digit positions
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      an_q    <= {NUM_DIGITS{1'b1}};
      seg_q   <= SEG_BLANK;
      cnt_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        IDLE, LOCKED: begin
          if (start_s) begin
            an_q    <= an;
            seg_q   <= seg;
            cnt_q   <= CNT_ONE;
            state_q <= accept_s ? LOCKED : SETTLE;
          end else if (state_q == IDLE || changed_s) begin
            cnt_q   <= CNT_ZERO;
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (start_s) begin
            an_q    <= an;
            seg_q   <= seg;
            cnt_q   <= CNT_ONE;
            state_q <= accept_s ? LOCKED : SETTLE;
          end else if (changed_s) begin
            cnt_q   <= CNT_ZERO;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_inc_s;
            state_q <= accept_s ? LOCKED : SETTLE;
          end
        end
        default: begin
          cnt_q   <= CNT_ZERO;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // frame assembly and output handshake
  always_comb begin
    frame_full_s = &mask_q;
    mask_d = (frame_full_s ? DIG_ZERO : mask_q) | (accept_s ? an_low_s : DIG_ZERO);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      work_bcd_d[4*i +: 4] = (accept_s && an_low_s[i]) ? dec_bcd_s   : work_bcd_q[4*i +: 4];
      work_err_d[i]        = (accept_s && an_low_s[i]) ? dec_err_s   : work_err_q[i];
      work_blank_d[i]      = (accept_s && an_low_s[i]) ? dec_blank_s : work_blank_q[i];
    end

    bcd_out_d     = bcd_out_q;
    digit_err_d   = digit_err_q;
    digit_blank_d = digit_blank_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    if (frame_full_s && (!frame_valid_q || frame_ready)) begin
      bcd_out_d     = work_bcd_q;
      digit_err_d   = work_err_q;
      digit_blank_d = work_blank_q;
      frame_valid_d = 1'b1;
    end else if (frame_full_s) begin
      overrun_d     = 1'b1;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end
  end

  // frame and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q        <= DIG_ZERO;
      work_bcd_q    <= {(4*NUM_DIGITS){1'b0}};
      work_err_q    <= DIG_ZERO;
      work_blank_q  <= DIG_ZERO;
      bcd_out_q     <= {(4*NUM_DIGITS){1'b0}};
      digit_err_q   <= DIG_ZERO;
      digit_blank_q <= DIG_ZERO;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      mask_q        <= mask_d;
      work_bcd_q    <= work_bcd_d;
      work_err_q    <= work_err_d;
      work_blank_q  <= work_blank_d;
      bcd_out_q     <= bcd_out_d;
      digit_err_q   <= digit_err_d;
      digit_blank_q <= digit_blank_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bcd_out     = bcd_out_q;
  assign digit_err   = digit_err_q;
  assign digit_blank = digit_blank_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (NUM_DIGITS=4, STABLE_CNT=4); inputs change and
// outputs are sampled on the falling clock edge.
module tb_seg7_capture;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PBLANK = 7'b1111111;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PBAD = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic [3:0]  digit_blank;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_g_bcd;
  logic [3:0]  exp_g_err;

  seg7_capture dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .bcd_out     (bcd_out),
    .digit_err   (digit_err),
    .digit_blank (digit_blank),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 5);
    hold(4'b1101, s1, 5);
    hold(4'b1011, s2, 5);
    hold(4'b0111, s3, 5);
  endtask

  initial begin
`ifdef SEG7_CAPTURE_HEX_EN
    exp_g_bcd = 16'h8AE0;
    exp_g_err = 4'b0010;
`else
    exp_g_bcd = 16'h8EE0;
    exp_g_err = 4'b0110;
`endif
    rst = 1'b1;
    an = 4'b1111;
    seg = PBLANK;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bcd",     32'(bcd_out),     32'h0);
    check("rst_err",     32'(digit_err),   32'h0);
    check("rst_blank",   32'(digit_blank), 32'h0);
    check("rst_valid",   32'(frame_valid), 32'h0);
    check("rst_overrun", 32'(overrun),     32'h0);
    rst = 1'b0;

    // digit0 held only 3 cycles must not count toward the frame
    hold(4'b1110, P1, 3);
    hold(4'b1101, P3, 5);
    hold(4'b1011, P0, 5);
    hold(4'b0111, P2, 5);
    check("short_hold_no_frame", 32'(frame_valid), 32'h0);
    hold(4'b1110, P1, 4);
    check("lat_before", 32'(frame_valid), 32'h0);
    hold(4'b1110, P1, 1);
    check("lat_after",   32'(frame_valid), 32'h1);
    check("frame1_bcd",  32'(bcd_out),     32'h2031);
    check("frame1_err",  32'(digit_err),   32'h0);
    check("frame1_blank", 32'(digit_blank), 32'h0);
    frame_ready = 1'b1;
    hold(4'b1110, P1, 1);
    frame_ready = 1'b0;
    check("accept1_drop", 32'(frame_valid), 32'h0);

    // scan 3,0,2,9
    hold(4'b1110, P3, 5);
    hold(4'b1101, P0, 5);
    hold(4'b1011, P2, 5);
    hold(4'b0111, P9, 4);
    check("scan2_lat_before", 32'(frame_valid), 32'h0);
    hold(4'b0111, P9, 1);
    check("scan2_valid", 32'(frame_valid), 32'h1);
    check("scan2_bcd",   32'(bcd_out),     32'h9203);
    check("scan2_err",   32'(digit_err),   32'h0);

    // back-to-back: ready coincides with the next offer
    hold(4'b1110, P1, 5);
    hold(4'b1101, P2, 5);
    hold(4'b1011, P3, 5);
    hold(4'b0111, P4, 4);
    check("pending_stable_bcd", 32'(bcd_out), 32'h9203);
    frame_ready = 1'b1;
    hold(4'b0111, P4, 1);
    frame_ready = 1'b0;
    check("b2b_valid",   32'(frame_valid), 32'h1);
    check("b2b_bcd",     32'(bcd_out),     32'h4321);
    check("b2b_overrun", 32'(overrun),     32'h0);

    // frame completes while one is pending and unaccepted
    scan(P8, P7, P6, P5);
    check("ovr_set",   32'(overrun),     32'h1);
    check("ovr_bcd",   32'(bcd_out),     32'h4321);
    check("ovr_valid", 32'(frame_valid), 32'h1);
    frame_ready = 1'b1;
    hold(4'b0111, P5, 1);
    frame_ready = 1'b0;
    check("ovr_accept_drop", 32'(frame_valid), 32'h0);
    check("ovr_sticky",      32'(overrun),     32'h1);

    // blank, unrecognised and hex-A patterns
    scan(PBLANK, PBAD, PA, P8);
    check("pat_valid", 32'(frame_valid), 32'h1);
    check("pat_bcd",   32'(bcd_out),     32'(exp_g_bcd));
    check("pat_err",   32'(digit_err),   32'(exp_g_err));
    check("pat_blank", 32'(digit_blank), 32'h1);
    frame_ready = 1'b1;
    hold(4'b0111, P8, 1);
    frame_ready = 1'b0;
    check("pat_accept_drop", 32'(frame_valid), 32'h0);

    // invalid digit selects capture nothing; digits 1..3 alone leave the frame open
    hold(4'b1100, P0, 10);
    hold(4'b1111, P0, 10);
    check("bad_an_no_frame", 32'(frame_valid), 32'h0);
    hold(4'b1101, P1, 5);
    hold(4'b1011, P2, 5);
    hold(4'b0111, P3, 5);
    check("partial_no_frame", 32'(frame_valid), 32'h0);

    // reset discards the partial frame and the sticky overrun
    rst = 1'b1;
    hold(4'b1111, PBLANK, 1);
    rst = 1'b0;
    check("mid_rst_valid",   32'(frame_valid), 32'h0);
    check("mid_rst_overrun", 32'(overrun),     32'h0);
    check("mid_rst_bcd",     32'(bcd_out),     32'h0);
    hold(4'b1110, P5, 5);
    check("post_rst_d0_no_frame", 32'(frame_valid), 32'h0);
    hold(4'b1101, P6, 5);
    hold(4'b1011, P7, 5);
    hold(4'b0111, P8, 4);
    check("post_rst_lat_before", 32'(frame_valid), 32'h0);
    hold(4'b0111, P8, 1);
    check("post_rst_valid",   32'(frame_valid), 32'h1);
    check("post_rst_bcd",     32'(bcd_out),     32'h8765);
    check("post_rst_overrun", 32'(overrun),     32'h0);
    check("post_rst_err",     32'(digit_err),   32'h0);
    check("post_rst_blank",   32'(digit_blank), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
